radial_area_accum: RTL and testbench
====================================

Name: radial_area_accum

Overview:
- Parametrised successor to the sphere-to-cartesian area stage.
- Accepts a stream of radius samples taken at N equally spaced angles per revolution and computes the enclosed polygon area: area = sin(2π/N)/2 · Σ r[i]·r[(i+1) mod N].
- Includes the closing edge, an input-ready handshake, revolution restart, saturation and an overflow flag.
- Sits between the range-sample source and downstream area consumers.

Parameters:
- RADIUS_W, 16, radius sample width (unsigned).
- N_SAMPLES, 4, samples per revolution; legal range 3..1024.
- SIN_COEF, 32768, sin(2π/N_SAMPLES)/2 in unsigned Q0.16; the default matches N=4.
- AREA_W, 26, output area width (unsigned).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  sample valid; a sample is accepted when en && ready at the rising edge.
- radius  in  RADIUS_W  radius sample.
- clr  in  1  synchronous revolution restart; discards the partial revolution.
- ready  out  1  block can accept a sample.
- area  out  AREA_W  last completed area; held until the next result.
- rdy  out  1  one-cycle pulse when area updates.
- ovf  out  1  saturation occurred on the current area; valid with rdy, held with area.

Behaviour:
- Reset: asynchronous, active-high; applies at any time, including mid-CLOSE or mid-SCALE.
  - State=ACCUM, idx=0, acc=0, first=0, prev=0.
  - area=0, rdy=0, ovf=0, ready=1.
  - No rdy is produced for a revolution interrupted by reset.
- Internal widths:
  - idx: clog2(N_SAMPLES) bits.
  - Product: 2·RADIUS_W bits.
  - acc: ACC_W = 2·RADIUS_W + clog2(N_SAMPLES) bits; acc never overflows.
- States: ACCUM, CLOSE, SCALE. ready=1 only in ACCUM.
- ACCUM, on an accepted sample:
  - idx==0: first<=radius, prev<=radius, acc<=0.
  - else: acc<=acc+prev·radius, prev<=radius.
  - idx increments; at idx==N_SAMPLES-1, idx wraps to 0 and state goes to CLOSE.
- CLOSE (1 cycle): acc<=acc+prev·first; go to SCALE.
- SCALE (1 cycle):
  - s = (acc·SIN_COEF)>>16, truncated (no rounding).
  - If s > 2^AREA_W-1: area<=all ones, ovf<=1; else area<=s, ovf<=0.
  - rdy<=1; go to ACCUM.
- rdy is high for exactly one cycle (the first ACCUM cycle after SCALE), then 0.
- Latency: last sample accepted at edge k → acc closed at edge k+1 → area/rdy registered at edge k+2 → rdy high during cycle k+2..k+3.
- ready is low for exactly 2 cycles per revolution.
- en while ready=0: sample is ignored, not buffered; the producer must hold or retry.
- Back-to-back revolutions: the first sample of the next revolution may be accepted in the cycle rdy is high.
- clr:
  - In ACCUM: idx<=0, acc<=0; any en in the same cycle is dropped (clr wins).
  - In CLOSE/SCALE: ignored; the revolution completes.
  - area, ovf and rdy are unaffected by clr.
- N_SAMPLES ≤ 2 or SIN_COEF=0: illegal; elaboration assertion fails.

Test Plan:
- N=4, radii 1000,1000,1000,1000 with en held high → ready drops for 2 cycles after the 4th accept; rdy pulses once 2 edges after the 4th accept; area=2000000, ovf=0.
- Radii 1000,2000,1000,2000 → products 4×2000000 → area=4000000, ovf=0. This checks the closing edge r[3]·r[0] is included.
- Radii 65535 ×4 → computed value 8589672450 exceeds 2^26-1 → area=67108863, ovf=1. Next revolution of 10 ×4 → area=200, ovf=0.
- clr after 2 accepted samples (also assert clr with en=1 in the same cycle), then 500 ×4 → area=500000; the dropped samples contribute nothing; exactly one rdy.
- en held continuously across two revolutions → samples offered during CLOSE/SCALE are ignored. Bench re-offers each sample when ready=1; expect two rdy pulses with correct areas, and the second revolution's first accept coincides with the first rdy.
- Assert rst during CLOSE → all outputs 0 immediately (asynchronous), no rdy. After release, a 1000 ×4 revolution → area=2000000.

Source files
------------

// File: rtl/radial_area_accum.sv
// radial_area_accum: polygon area from N equally spaced radius samples per revolution,
// area = sin(2*pi/N)/2 * sum r[i]*r[(i+1) mod N], saturated to AREA_W bits.
module radial_area_accum #(
    parameter int RADIUS_W  = 16,
    parameter int N_SAMPLES = 4,
    parameter int SIN_COEF  = 32768,
    parameter int AREA_W    = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [RADIUS_W-1:0] radius,
    input  logic                clr,
    output logic                ready,
    output logic [AREA_W-1:0]   area,
    output logic                rdy,
    output logic                ovf
);
    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam int ACC_W = 2 * RADIUS_W + IDX_W;
    localparam int SW    = ACC_W > AREA_W ? ACC_W : AREA_W;
    localparam logic [15:0]      COEF = 16'(SIN_COEF);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {ACCUM, CLOSE, SCALE} state_t;

    state_t                state, state_n;
    logic [IDX_W-1:0]      idx;
    logic [RADIUS_W-1:0]   first, prev;
    logic [ACC_W-1:0]      acc;
    logic [2*RADIUS_W-1:0] prod;
    logic [SW-1:0]         s;
    logic                  take, sat;

    if (N_SAMPLES < 3 || N_SAMPLES > 1024 || SIN_COEF <= 0 || SIN_COEF > 65535) begin : g_bad_params
        $error("radial_area_accum: illegal N_SAMPLES or SIN_COEF");
    end

    assign ready = state == ACCUM;
    assign take  = ready && en && !clr;
    // One multiplier serves both the running edges and the closing edge
    assign prod  = prev * (state == CLOSE ? first : radius);
    assign s     = SW'(({16'b0, acc} * COEF) >> 16);
    assign sat   = s > SW'({AREA_W{1'b1}});

    always_comb begin
        state_n = state == CLOSE ? SCALE :
                  state == SCALE ? ACCUM :
                  (take && idx == LAST) ? CLOSE : ACCUM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            acc   <= '0;
            first <= '0;
            prev  <= '0;
            area  <= '0;
            rdy   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            rdy <= state == SCALE;
            if (state == SCALE) begin
                area <= sat ? '1 : s[AREA_W-1:0];
                ovf  <= sat;
            end
            if (state == CLOSE) begin
                acc <= acc + ACC_W'(prod);
            end else if (ready && clr) begin
                idx <= '0;
                acc <= '0;
            end else if (take) begin
                if (idx == '0) begin
                    first <= radius;
                    prev  <= radius;
                    acc   <= '0;
                end else begin
                    acc  <= acc + ACC_W'(prod);
                    prev <= radius;
                end
                idx <= idx == LAST ? '0 : idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_radial_area_accum.sv
// tb_radial_area_accum: table-driven revolutions plus hand-written corner sequences,
// with a scoreboard of expected areas popped on every rdy pulse.
module tb_radial_area_accum;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
    logic [15:0] radius = '0;
    logic        ready, rdy, ovf;
    logic [25:0] area;
    int          checks = 0, errors = 0, rdy_count = 0, n0;
    logic        rdy_at_drive;

    typedef struct packed {logic [25:0] area; logic ovf;} exp_t;
    typedef struct packed {logic [3:0][15:0] r; logic [25:0] area; logic ovf;} vec_t;
    exp_t sb[$];
    vec_t vecs[6];

    radial_area_accum dut (
        .clk(clk), .rst(rst), .en(en), .radius(radius), .clr(clr),
        .ready(ready), .area(area), .rdy(rdy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rdy === 1'b1) begin
            rdy_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got rdy=1 with area %0d, want no pulse", area);
            end else begin
                e = sb.pop_front();
                check("area", area, e.area);
                check("ovf", ovf, e.ovf);
            end
        end
    end

    // Called and returns at a falling edge; holds en high until the sample is taken
    task automatic send(input logic [15:0] r);
        int t = 0;
        while (ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready stayed %b, want 1", ready);
        end
        rdy_at_drive = rdy;
        radius = r;
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_rev(input logic [3:0][15:0] r, input logic [25:0] a, input logic o);
        for (int i = 3; i >= 0; i--) send(r[i]);
        sb.push_back({a, o});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = {16'd1000, 16'd2000, 16'd1000, 16'd2000, 26'd4000000, 1'b0};
        vecs[1] = {16'd65535, 16'd65535, 16'd65535, 16'd65535, 26'd67108863, 1'b1};
        vecs[2] = {16'd10, 16'd10, 16'd10, 16'd10, 26'd200, 1'b0};
        vecs[3] = {16'd0, 16'd65535, 16'd0, 16'd65535, 26'd0, 1'b0};
        vecs[4] = {16'd3, 16'd5, 16'd7, 16'd9, 26'd70, 1'b0};
        vecs[5] = {16'd1, 16'd1, 16'd1, 16'd1, 26'd2, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_area", area, 0);
        check("reset_rdy", rdy, 0);
        check("reset_ovf", ovf, 0);
        check("reset_ready", ready, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) send(16'd1000);
        sb.push_back({26'd2000000, 1'b0});
        check("close_ready", ready, 0);
        check("close_rdy", rdy, 0);
        @(negedge clk);
        check("scale_ready", ready, 0);
        check("scale_rdy", rdy, 0);
        @(negedge clk);
        check("post_ready", ready, 1);
        check("post_rdy", rdy, 1);
        en = 1'b0;
        @(negedge clk);
        check("rdy_one_cycle", rdy, 0);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send_rev(vecs[v].r, vecs[v].area, vecs[v].ovf);
            en = 1'b0;
            repeat (3) @(negedge clk);
        end

        n0 = rdy_count;
        send(16'd700);
        send(16'd800);
        clr = 1'b1;
        en = 1'b1;
        radius = 16'd900;
        @(negedge clk);
        clr = 1'b0;
        en = 1'b0;
        send_rev({16'd500, 16'd500, 16'd500, 16'd500}, 26'd500000, 1'b0);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_rdy_count", rdy_count - n0, 1);

        n0 = rdy_count;
        send_rev({16'd1000, 16'd2000, 16'd1000, 16'd2000}, 26'd4000000, 1'b0);
        send(16'd3);
        check("b2b_accept_on_rdy", rdy_at_drive, 1);
        send(16'd5);
        send(16'd7);
        send(16'd9);
        sb.push_back({26'd70, 1'b0});
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_rdy_count", rdy_count - n0, 2);

        for (int i = 0; i < 4; i++) send(16'd1000);
        en = 1'b0;
        check("pre_rst_close", ready, 0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_area", area, 0);
        check("async_rst_ovf", ovf, 0);
        check("async_rst_rdy", rdy, 0);
        check("async_rst_ready", ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_rev({16'd1000, 16'd1000, 16'd1000, 16'd1000}, 26'd2000000, 1'b0);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
